// File: rtl/bus_responder.sv
// Memory-side responder for a 16-bit address / 8-bit data CPU bus.
// Decodes on-chip RAM, an external ROM window and a byte I/O port (TX FIFO + RX holding register).
module bus_responder #(
    parameter int RAM_AW     = 11,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] address,
    input  logic        read_write,
    input  logic [7:0]  data_write,
    output logic [7:0]  data_read,
    output logic [14:0] rom_address,
    input  logic [7:0]  rom_data,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [15:0] TXDATA_ADDR = 16'h4000;
    localparam logic [15:0] STATUS_ADDR = 16'h4001;
    localparam logic [15:0] RXDATA_ADDR = 16'h4002;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic sel_ram;
    logic sel_rom;
    logic sel_tx;
    logic sel_status;
    logic sel_rx;
    logic bus_wr;
    logic bus_rd;

    always_comb begin
        sel_ram    = (address >> RAM_AW) == 16'd0;
        sel_rom    = address[15];
        sel_tx     = (address == TXDATA_ADDR);
        sel_status = (address == STATUS_ADDR);
        sel_rx     = (address == RXDATA_ADDR);
        bus_wr     = !read_write;
        bus_rd     = read_write;
    end

    assign rom_address = address[14:0];

    // ------------------------------------------------------------------
    // On-chip RAM: asynchronous read, untouched by reset
    // ------------------------------------------------------------------
    logic [7:0] ram_mem [2**RAM_AW];
    logic [7:0] ram_rd;

    always_ff @(posedge clk) begin
        if (sel_ram && bus_wr) begin
            ram_mem[address[RAM_AW-1:0]] <= data_write;
        end
    end

    assign ram_rd = ram_mem[address[RAM_AW-1:0]];

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          tx_ovf_q, tx_ovf_d;
    logic          tx_empty;
    logic          tx_full;
    logic          push;
    logic          push_acc;
    logic          pop;
    logic          ovf_set;
    logic          ovf_clr;

    always_comb begin
        tx_empty = (count_q == '0);
        tx_full  = (count_q == CW'(FIFO_DEPTH));
        pop      = !tx_empty && out_ready;
        push     = sel_tx && bus_wr;
        // A full FIFO still accepts a byte when the head leaves in the same cycle.
        push_acc = push && (!tx_full || pop);
        ovf_set  = push && tx_full && !pop;
        ovf_clr  = sel_status && bus_wr && data_write[3];

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        tx_ovf_d = tx_ovf_q;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        case ({push_acc, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (ovf_set) begin
            tx_ovf_d = 1'b1;
        end else if (ovf_clr) begin
            tx_ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            tx_ovf_q <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            tx_ovf_q <= tx_ovf_d;
        end
    end

    // Storage needs no reset: slots are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (!rst && push_acc) begin
            fifo_mem[wr_ptr_q] <= data_write;
        end
    end

    assign out_valid = !tx_empty;
    assign out_data  = tx_empty ? 8'h00 : fifo_mem[rd_ptr_q];

    // ------------------------------------------------------------------
    // Receive holding register
    // ------------------------------------------------------------------
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_capture;
    logic       rx_clear;

    always_comb begin
        rx_capture = in_valid && !rx_valid_q;
        rx_clear   = sel_rx && bus_rd;
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        // Capture wins: a handshake that already completed must not lose its byte.
        if (rx_capture) begin
            rx_valid_d = 1'b1;
            rx_data_d  = in_data;
        end else if (rx_clear) begin
            rx_valid_d = 1'b0;
            rx_data_d  = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
        end else begin
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign in_ready = !rx_valid_q;

    // ------------------------------------------------------------------
    // Read data mux
    // ------------------------------------------------------------------
    always_comb begin
        data_read = 8'hFF;
        if (sel_ram) begin
            data_read = ram_rd;
        end else if (sel_rom) begin
            data_read = rom_data;
        end else if (sel_tx) begin
            data_read = 8'h00;
        end else if (sel_status) begin
            data_read = {4'b0000, tx_ovf_q, rx_valid_q, tx_empty, tx_full};
        end else if (sel_rx) begin
            data_read = rx_data_q;
        end
    end

endmodule

// File: tb/tb_bus_responder.sv
// Randomized bench for bus_responder: a queue/array model predicts every output each cycle,
// and directed scenarios pin the model with literal expectations.
module tb_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] address;
    logic        read_write;
    logic [7:0]  data_write;
    logic [7:0]  data_read;
    logic [14:0] rom_address;
    logic [7:0]  rom_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;

    logic        rom_ovr_en;
    logic [7:0]  rom_ovr;

    int n_total = 0;
    int n_pass  = 0;
    bit model_ok = 1'b0;

    always #5 clk = ~clk;

    assign rom_data = rom_ovr_en ? rom_ovr : (rom_address[7:0] ^ {1'b0, rom_address[14:8]});

    bus_responder #(.RAM_AW(11), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .address(address), .read_write(read_write),
        .data_write(data_write), .data_read(data_read), .rom_address(rom_address),
        .rom_data(rom_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
    );

    // ---------------- behavioural model ----------------
    logic [7:0] m_ram [2048];
    bit         m_known [2048];
    logic [7:0] m_txq [$];
    bit         m_ovf;
    bit         m_rxv;
    logic [7:0] m_rxd;

    function automatic logic [7:0] rom_model(input logic [15:0] a);
        if (rom_ovr_en) return rom_ovr;
        return a[7:0] ^ {1'b0, a[14:8]};
    endfunction

    function automatic bit exp_read(input logic [15:0] a, output logic [7:0] v);
        v = 8'hFF;
        if (a < 16'd2048) begin
            v = m_ram[a[10:0]];
            return m_known[a[10:0]];
        end
        if (a >= 16'h8000)      v = rom_model(a);
        else if (a == 16'h4000) v = 8'h00;
        else if (a == 16'h4001) v = {4'b0, m_ovf, m_rxv, m_txq.size() == 0, m_txq.size() == 4};
        else if (a == 16'h4002) v = m_rxv ? m_rxd : 8'h00;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        int  sz;
        bit  pop_now;
        bit  ovf_set;
        if (!read_write && address < 16'd2048) begin
            m_ram[address[10:0]]   = data_write;
            m_known[address[10:0]] = 1'b1;
        end
        if (rst) begin
            m_txq.delete();
            m_ovf = 1'b0;
            m_rxv = 1'b0;
            m_rxd = 8'h00;
        end else begin
            sz      = m_txq.size();
            pop_now = (sz > 0) && out_ready;
            ovf_set = 1'b0;
            if (pop_now) void'(m_txq.pop_front());
            if (!read_write && address == 16'h4000) begin
                if (sz < 4 || pop_now) m_txq.push_back(data_write);
                else ovf_set = 1'b1;
            end
            if (ovf_set) m_ovf = 1'b1;
            else if (!read_write && address == 16'h4001 && data_write[3]) m_ovf = 1'b0;
            if (in_valid && !m_rxv) begin
                m_rxv = 1'b1;
                m_rxd = in_data;
            end else if (read_write && address == 16'h4002) begin
                m_rxv = 1'b0;
                m_rxd = 8'h00;
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- per-cycle compare process ----------------
    always @(negedge clk) begin
        logic [7:0] v;
        if (model_ok) begin
            check("rom_address", 16'(rom_address), 16'(address[14:0]));
            if (exp_read(address, v)) check("data_read", 16'(data_read), 16'(v));
            check("out_valid", 16'(out_valid), 16'(m_txq.size() != 0));
            if (m_txq.size() != 0) check("out_data", 16'(out_data), 16'(m_txq[0]));
            check("in_ready", 16'(in_ready), 16'(!m_rxv));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic bus(input logic [15:0] a, input logic rw, input logic [7:0] d);
        address = a; read_write = rw; data_write = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus(16'h2000, 1'b1, 8'h00);
    endtask

    task automatic push(input logic [7:0] b);
        bus(16'h4000, 1'b0, b);
        tick();
    endtask

    task automatic expect_status(input string name, input logic [7:0] exp);
        bus(16'h4001, 1'b1, 8'h00);
        #1;
        check(name, 16'(data_read), 16'(exp));
    endtask

    initial begin
        logic [7:0] seq [4];
        rst = 1'b1; out_ready = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        rom_ovr_en = 1'b0; rom_ovr = 8'h00;
        idle();
        tick();
        tick();
        expect_status("reset_status", 8'h02);
        check("reset_out_valid", 16'(out_valid), 16'd0);
        check("reset_out_data", 16'(out_data), 16'h00);
        check("reset_in_ready", 16'(in_ready), 16'd1);
        rst = 1'b0;
        tick();
        model_ok = 1'b1;

        // RAM round trip and out-of-range hole
        bus(16'h0123, 1'b0, 8'hA5); tick();
        bus(16'h0123, 1'b1, 8'h00); #1 check("ram_rt", 16'(data_read), 16'hA5);
        bus(16'h0800, 1'b1, 8'h00); #1 check("ram_hole", 16'(data_read), 16'hFF);
        tick();

        // ROM window
        rom_ovr_en = 1'b1; rom_ovr = 8'h34;
        bus(16'hFFFC, 1'b1, 8'h00); #1;
        check("rom_addr", 16'(rom_address), 16'h7FFC);
        check("rom_data", 16'(data_read), 16'h34);
        tick();
        rom_ovr_en = 1'b0;
        bus(16'h9000, 1'b0, 8'h77); tick();
        bus(16'h9000, 1'b1, 8'h00); #1 check("rom_wr_ignored", 16'(data_read), 16'h10);
        tick();

        // FIFO order, full, overflow
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        expect_status("fifo_full", 8'h01); tick();
        push(8'h55);
        expect_status("fifo_ovf", 8'h09);
        out_ready = 1'b1;
        idle();
        seq = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            #1 check("drain_data", 16'(out_data), 16'(seq[i]));
            tick();
        end
        check("drained_valid", 16'(out_valid), 16'd0);
        expect_status("drained_status", 8'h0A); tick();
        bus(16'h4001, 1'b0, 8'h08); tick();
        expect_status("ovf_cleared", 8'h02); tick();

        // push and pop while full
        out_ready = 1'b0;
        push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
        out_ready = 1'b1;
        bus(16'h4000, 1'b0, 8'h66); #1 check("full_head", 16'(out_data), 16'hA1);
        tick();
        out_ready = 1'b0;
        expect_status("full_pushpop", 8'h01); tick();
        out_ready = 1'b1;
        idle();
        seq = '{8'hA2, 8'hA3, 8'hA4, 8'h66};
        for (int i = 0; i < 4; i++) begin
            #1 check("pushpop_order", 16'(out_data), 16'(seq[i]));
            tick();
        end
        out_ready = 1'b0;

        // RX handshake
        in_data = 8'h7E; in_valid = 1'b1; tick();
        in_data = 8'h7F;
        expect_status("rx_status", 8'h06);
        check("rx_busy", 16'(in_ready), 16'd0);
        tick();
        bus(16'h4002, 1'b1, 8'h00); #1 check("rx_first", 16'(data_read), 16'h7E);
        tick();
        idle(); #1 check("rx_ready_again", 16'(in_ready), 16'd1);
        tick();
        in_valid = 1'b0;
        bus(16'h4002, 1'b1, 8'h00); #1 check("rx_second", 16'(data_read), 16'h7F);
        tick();
        idle(); tick();

        // reset mid-operation
        push(8'hB1); push(8'hB2);
        in_data = 8'h3C; in_valid = 1'b1; idle(); tick();
        in_valid = 1'b0;
        bus(16'h0042, 1'b0, 8'h5A); tick();
        idle(); rst = 1'b1; tick(); rst = 1'b0;
        expect_status("rst_status", 8'h02);
        check("rst_out_valid", 16'(out_valid), 16'd0);
        check("rst_in_ready", 16'(in_ready), 16'd1);
        bus(16'h0042, 1'b1, 8'h00); #1 check("rst_ram_kept", 16'(data_read), 16'h5A);
        tick();

        // randomized traffic, checked by the compare process
        for (int c = 0; c < 4000; c++) begin
            logic [15:0] a;
            case ($urandom_range(0, 9))
                0, 1:    a = 16'($urandom_range(0, 15));
                2:       a = 16'($urandom_range(2032, 2047));
                3, 4:    a = 16'h4000;
                5:       a = 16'h4001;
                6:       a = 16'h4002;
                7:       a = 16'h8000 | 16'($urandom_range(0, 32767));
                default: a = ($urandom_range(0, 1) == 0) ? 16'h4003 : 16'h0800 + 16'($urandom_range(0, 16'h37FF));
            endcase
            bus(a, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            out_ready = ($urandom_range(0, 2) == 0);
            in_valid  = ($urandom_range(0, 3) == 0);
            in_data   = 8'($urandom_range(0, 255));
            rst       = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bus_responder.md
# bus_responder

Memory-side responder for the CPU's 16-bit address / 8-bit data bus. It decodes every CPU access and provides the following targets:

- on-chip RAM;
- a pass-through window to an external ROM;
- a memory-mapped byte I/O port: a transmit FIFO with a valid/ready output, and a single-entry receive holding register.

It sits at top level beside the cpu and connects directly to its `address`, `read_write`, `data_write` and `data_read` pins.

## Interface
Parameters:
- `RAM_AW`, default 11: RAM address width. RAM occupies 0x0000 to 2^RAM_AW−1 and must not exceed 0x3FFF.
- `FIFO_DEPTH`, default 4: number of transmit FIFO entries. Must be a power of two, 2 or more.

Ports:
- `clk` in 1: the single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `address` in 16: CPU bus address.
- `read_write` in 1: 1 = read, 0 = write.
- `data_write` in 8: CPU write data.
- `data_read` out 8: read data to the CPU. Combinational from `address`.
- `rom_address` out 15: equals `address[14:0]`, always driven.
- `rom_data` in 8: external ROM byte, combinational from `rom_address`.
- `out_data` out 8: transmit FIFO head byte.
- `out_valid` out 1: FIFO not empty.
- `out_ready` in 1: sink accepts the head byte this cycle.
- `in_data` in 8: incoming byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: holding register is empty.

## Operation
Address map:
- **0x0000–RAM top (RAM):**
  - Read returns `ram[address]` asynchronously.
  - Write stores `data_write` at the clock edge.
  - Contents are not affected by reset.
- **0x4000 TXDATA:**
  - Write pushes `data_write` into the FIFO.
  - Read returns 0x00.
- **0x4001 STATUS (read):** bit0 tx_full, bit1 tx_empty, bit2 rx_valid, bit3 tx_overflow; bits 7:4 read 0.
- **0x4001 STATUS (write):** writing bit3=1 clears tx_overflow. All other bits are ignored.
- **0x4002 RXDATA:**
  - Read returns the holding byte (0x00 when empty).
  - Each clock edge with this address and `read_write`=1 clears rx_valid.
- **0x8000–0xFFFF:** read returns `rom_data`; writes are ignored.
- **Any other address:** read returns 0xFF; writes are ignored.

Bus accesses take effect on every cycle they are presented. A CPU holding a write address for N cycles performs N writes: N RAM stores, or N FIFO pushes.

Transmit FIFO:
- Circular buffer with read pointer, write pointer and a count of width log2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- `pop` = `out_valid & out_ready`.
- `push` = write to 0x4000.
- Push is accepted when count < FIFO_DEPTH, or when pop is true in the same cycle.
- When full and push without pop: the byte is dropped and tx_overflow is set (sticky).
- Simultaneous accepted push and pop: count unchanged, both pointers advance.
- Pop when empty cannot occur, because `out_valid`=0.
- tx_overflow set and clear in the same cycle: set wins.

Receive holding register:
- `in_ready` = !rx_valid.
- When `in_valid & in_ready`, capture `in_data` and set rx_valid.
- A CPU RXDATA read and a capture cannot coincide, since `in_ready`=0 while rx_valid=1. The next byte is captured no earlier than the cycle after the clearing read.

Reset values:
- FIFO empty: pointers and count 0, `out_valid`=0, `out_data`=0x00.
- rx_valid=0, holding byte 0x00, `in_ready`=1, tx_overflow=0.
- `data_read` follows the decode immediately. ROM reads remain valid during reset.

Reset mid-operation discards all FIFO contents and any held RX byte. RAM keeps its contents.

## Timing
- **Read latency:** zero cycles. `data_read` is valid in the same cycle as `address`, which matches the CPU's same-cycle capture.
- **Write latency:** a RAM write at edge k is visible to a read of the same address from cycle k+1.
- **TX path:** a byte pushed at edge k into an empty FIFO gives `out_valid`=1 and `out_data`=byte from cycle k+1. `out_data` holds its value until the edge where `out_ready`=1.
- **RX path:**
  - A byte captured at edge k sets `in_ready`=0 and makes STATUS bit2 = 1 from cycle k+1.
  - A RXDATA read clearing at edge m sets `in_ready`=1 from cycle m+1.
- **STATUS:** reflects register state of the current cycle, not the pending update.

## Test plan
1. **RAM round-trip:** write 0xA5 to 0x0123, then read 0x0123 → `data_read`=0xA5 the cycle after the write. Read 0x0800 (RAM_AW=11) → 0xFF.
2. **ROM window:** `address`=0xFFFC with `rom_data` driven 0x34 → `rom_address`=0x7FFC, `data_read`=0x34. A write to 0x9000 changes nothing.
3. **FIFO order and full:**
   - With `out_ready`=0, push 0x11, 0x22, 0x33, 0x44 → STATUS=0x01.
   - Push 0x55 → dropped, STATUS=0x09.
   - Raise `out_ready` → `out_data` sequence 0x11, 0x22, 0x33, 0x44, then `out_valid`=0 and STATUS=0x0A.
   - Write 0x08 to STATUS → 0x02.
4. **Push and pop when full:** FIFO full, `out_ready`=1, push 0x66 in the same cycle → accepted, count stays 4, no overflow, 0x66 emerges last.
5. **RX handshake:**
   - `in_valid`=1 with 0x7E → `in_ready`=0 next cycle, STATUS bit2=1.
   - A second byte 0x7F is held off.
   - Read 0x4002 → 0x7E. 0x7F is captured the cycle after the read.
6. **Reset mid-operation:** FIFO holding 2 bytes, rx_valid=1, assert `rst` for one cycle → `out_valid`=0, `in_ready`=1, STATUS=0x02. A RAM byte written before reset still reads back.
